// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
//   op_e     - 3-bit opcode, all eight codes defined
//   state_e  - control FSM states
//   flags_t  - {N,Z,C,V} flag bundle, packed so it maps 1:1 onto the flags port
//   FLAG_*   - bit positions of each flag within flags_t
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHR = 3'd2,
    OP_SHL = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one multiplier bit
// per clock, LSB first.
//   clk, rst  - clock, synchronous active-high reset (aborts any operation)
//   start     - load a/b and begin; must only be asserted while !busy
//   a, b      - multiplicand, multiplier (sampled on start)
//   busy      - iteration in progress
//   done      - high during the final iteration cycle; p is the full product
//               in that cycle, so the caller can register it on the same edge
//   p         - next accumulator value (full 2*WIDTH-bit product when done)
module alu_mul_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy  = busy_q;
  assign done  = busy_q && (cnt_q == LAST);
  assign p     = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on both sides and NZCV flags.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake; in_ready depends only on state
//                          and out_ready
//   a, b, op             - operands and opcode (b doubles as shift amount)
//   out_valid / out_ready- result handshake; q/flags held while stalled
//   q, flags             - registered result and {N,Z,C,V}
// Single-cycle ops go IDLE/DONE -> DONE in one edge; mul detours through
// BUSY for WIDTH cycles while alu_mul_iter iterates.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [3:0]       flags
);

  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  state_e             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   q_q;
  flags_t             flags_q;

  op_e                op_in;
  logic               accept, mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH:0]     sum, dif;
  logic [WIDTH-1:0]   res_d;
  logic               c_d, v_d;
  flags_t             res_flags_d, mul_flags_d;

  assign op_in     = op_e'(op);
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_in == OP_MUL);

  // One extra bit catches the carry on add and the borrow on sub.
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_in)
      OP_ADD: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = dif[WIDTH-1:0];
        c_d   = dif[WIDTH];
        v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      // Shift amount is the full value of b; anything >= WIDTH flushes to 0.
      OP_SHR:  res_d = (b >= WLIM) ? '0 : (a >> b);
      OP_SHL:  res_d = (b >= WLIM) ? '0 : (a << b);
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      default: res_d = '0;  // OP_MUL is handled by the iterative unit
    endcase
  end

  assign res_flags_d = '{n: res_d[WIDTH-1], z: (res_d == '0), c: c_d, v: v_d};
  assign mul_flags_d = '{n: mul_p[WIDTH-1], z: (mul_p[WIDTH-1:0] == '0),
                         c: |mul_p[2*WIDTH-1:WIDTH], v: 1'b0};

  alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        // DONE with out_ready behaves exactly like IDLE for a new accept,
        // giving back-to-back throughput for single-cycle ops.
        IDLE, DONE: begin
          if (accept) begin
            if (op_in == OP_MUL) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              q_q         <= res_d;
              flags_q     <= res_flags_d;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (mul_busy && mul_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            q_q         <= mul_p[WIDTH-1:0];
            flags_q     <= mul_flags_d;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq at
// WIDTH=8. Inputs are driven 1ns after the rising edge, outputs sampled there.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, q;
  logic [2:0]   op;
  logic [3:0]   flags;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait (bounded) for in_ready, cross the accept edge and
  // return 1ns after it with in_valid dropped.
  task automatic issue(input op_e o, input logic [W-1:0] av, input logic [W-1:0] bv);
    int guard;
    in_valid = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic res(input string tag, input logic [W-1:0] eq, input logic [3:0] ef);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_q"}, {24'd0, q}, {24'd0, eq});
    chk({tag, "_flg"}, {28'd0, flags}, {28'd0, ef});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 3'd0;
    step(); step();
    rst = 1'b0;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_flg", {28'd0, flags}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    // add: carry out, then signed overflow (flags are {N,Z,C,V})
    issue(OP_ADD, 8'd200, 8'd100); res("add_c", 8'd44, 4'b0010);
    issue(OP_ADD, 8'd100, 8'd100); res("add_v", 8'd200, 4'b1001);

    // sub borrow, xor to zero
    issue(OP_SUB, 8'd5, 8'd7);       res("sub", 8'd254, 4'b1010);
    issue(OP_XOR, 8'hAA, 8'hAA);     res("xor", 8'h00, 4'b0100);

    // shifts, including amount >= WIDTH; shl never sets C
    issue(OP_SHR, 8'h81, 8'd1);      res("shr1", 8'h40, 4'b0000);
    issue(OP_SHR, 8'h81, 8'd9);      res("shr9", 8'h00, 4'b0100);
    issue(OP_SHL, 8'h81, 8'd1);      res("shl1", 8'h02, 4'b0000);
    issue(OP_SHL, 8'h01, 8'd7);      res("shl7", 8'h80, 4'b1000);
    issue(OP_AND, 8'hF0, 8'h3C);     res("and", 8'h30, 4'b0000);
    issue(OP_OR,  8'h0F, 8'h80);     res("or",  8'h8F, 4'b1000);

    // mul 15*17 = 255: busy 8 cycles, result 9 cycles after accept;
    // operands scrambled during BUSY must not matter
    issue(OP_MUL, 8'd15, 8'd17);
    for (int i = 1; i <= 8; i++) begin
      chk("mul_busy_rdy", {31'd0, in_ready}, 32'd0);
      chk("mul_busy_vld", {31'd0, out_valid}, 32'd0);
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom);
      step();
    end
    res("mul255", 8'd255, 4'b1000);

    // 16*16 = 256: low byte zero, high bit set
    issue(OP_MUL, 8'd16, 8'd16);
    for (int i = 1; i <= 8; i++) step();
    res("mul256", 8'd0, 4'b0110);

    // backpressure: result held for 5 stalled cycles, then release with a
    // fresh op in the same cycle
    step();
    out_ready = 1'b0;
    issue(OP_ADD, 8'd3, 8'd4);
    for (int i = 0; i < 5; i++) begin
      res("bp_hold", 8'd7, 4'b0000);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    issue(OP_ADD, 8'd10, 8'd20);     res("bp_next", 8'd30, 4'b0000);

    // reset pulsed three cycles into a multiply aborts it
    step();
    issue(OP_MUL, 8'd15, 8'd17);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_vld", {31'd0, out_valid}, 32'd0);
    chk("abort_q", {24'd0, q}, 32'd0);
    chk("abort_flg", {28'd0, flags}, 32'd0);
    chk("abort_rdy", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("abort_quiet", {31'd0, out_valid}, 32'd0);
      step();
    end
    issue(OP_ADD, 8'd1, 8'd1);       res("post_abort", 8'd2, 4'b0000);
    chk("flag_idx_z", {31'd0, flags[FLAG_Z]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
